// File: rtl/loop_apu.sv
// Address processing unit: turns the loop controller's per-depth step stream into
// strided per-lane addresses, rewinding to the loop-start snapshot on a loop's last step.
module loop_apu #(
    parameter int BITS                  = 18,
    parameter int ADDR_BITS             = 20,
    parameter int LOOP_LOG_CNT          = 3,
    parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                cfg_stride_we,
    input  logic [LOOP_LOG_CNT-1:0]                             cfg_depth,
    input  logic [ADDR_BITS-1:0]                                cfg_stride,
    input  logic                                                cfg_base_we,
    input  logic [ADDR_BITS-1:0]                                cfg_base,
    input  logic                                                enable,
    input  logic                                                is_start_loop,
    input  logic [LOOP_LOG_CNT-1:0]                             loop_depth,
    input  logic [BITS-1:0]                                     cur_di,
    input  logic                                                loop_done,
    output logic [(2**SUPERSCALAR_LOG_WIDTH)*ADDR_BITS-1:0]     lane_addr,
    output logic [(2**SUPERSCALAR_LOG_WIDTH)-1:0]               lane_valid,
    output logic                                                out_valid,
    output logic [ADDR_BITS-1:0]                                cur_addr
);

    localparam int LOOP_CNT = 2 ** LOOP_LOG_CNT;
    localparam int SW       = 2 ** SUPERSCALAR_LOG_WIDTH;
    localparam int EW       = SUPERSCALAR_LOG_WIDTH + 1;
    localparam logic [BITS-1:0] SW_DI = BITS'(SW);

    // Small multiplier: eff never exceeds SW, so a few shifted adds suffice.
    function automatic logic [ADDR_BITS-1:0] shift_add(input logic [ADDR_BITS-1:0] s,
                                                       input logic [EW-1:0]        m);
        logic [ADDR_BITS-1:0] acc;
        acc = '0;
        for (int b = 0; b < EW; b++) begin
            if (m[b]) acc = acc + (s << b);
            else      acc = acc;
        end
        return acc;
    endfunction

    logic [ADDR_BITS-1:0]       r_stride [LOOP_CNT];
    logic [ADDR_BITS-1:0]       r_snap   [LOOP_CNT];
    logic [ADDR_BITS-1:0]       r_cur_addr;
    logic [SW*ADDR_BITS-1:0]    r_lane_addr;
    logic [SW-1:0]              r_lane_valid;
    logic                       r_out_valid;

    logic                       w_step;
    logic                       w_start;
    logic [EW-1:0]              w_eff;
    logic [ADDR_BITS-1:0]       w_stride;
    logic [ADDR_BITS-1:0]       w_next_addr;
    logic [SW*ADDR_BITS-1:0]    w_lanes;
    logic [SW-1:0]              w_mask;

    // Decode the step, clamp the iteration count and build lane addresses and the next address.
    always_comb begin
        w_start     = enable && is_start_loop;
        w_step      = enable && !is_start_loop && (cur_di != {BITS{1'b0}});
        w_stride    = r_stride[loop_depth];
        w_lanes     = '0;
        w_mask      = '0;
        w_next_addr = r_cur_addr;
        if (cur_di > SW_DI) w_eff = EW'(SW);
        else                w_eff = cur_di[EW-1:0];
        for (int k = 0; k < SW; k++) begin
            w_lanes[k*ADDR_BITS +: ADDR_BITS] = r_cur_addr + shift_add(w_stride, EW'(k));
            if (EW'(k) < w_eff) w_mask[k] = 1'b1;
            else                w_mask[k] = 1'b0;
        end
        // Base load outranks the step's own address update; lanes still use the old address.
        if (cfg_base_we)          w_next_addr = cfg_base;
        else if (w_step) begin
            if (loop_done)        w_next_addr = r_snap[loop_depth];
            else                  w_next_addr = r_cur_addr + shift_add(w_stride, w_eff);
        end else                  w_next_addr = r_cur_addr;
    end

    // Per-depth stride table; a write is visible only from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LOOP_CNT; i++) r_stride[i] <= '0;
        end else if (cfg_stride_we) begin
            r_stride[cfg_depth] <= cfg_stride;
        end
    end

    // Running address and loop-start snapshots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_addr <= '0;
            for (int i = 0; i < LOOP_CNT; i++) r_snap[i] <= '0;
        end else begin
            r_cur_addr <= w_next_addr;
            if (w_start && !cfg_base_we) r_snap[loop_depth] <= r_cur_addr;
        end
    end

    // Registered lane outputs, live for exactly one cycle after a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_addr  <= '0;
            r_lane_valid <= '0;
            r_out_valid  <= 1'b0;
        end else if (w_step) begin
            r_lane_addr  <= w_lanes;
            r_lane_valid <= w_mask;
            r_out_valid  <= 1'b1;
        end else begin
            r_lane_addr  <= '0;
            r_lane_valid <= '0;
            r_out_valid  <= 1'b0;
        end
    end

    assign lane_addr  = r_lane_addr;
    assign lane_valid = r_lane_valid;
    assign out_valid  = r_out_valid;
    assign cur_addr   = r_cur_addr;

endmodule

// File: tb/tb_loop_apu.sv
// Self-checking bench for loop_apu: directed scenarios plus randomized steps against
// a behavioural address model.
module tb_loop_apu;
    localparam int BITS = 18;
    localparam int AB   = 20;
    localparam int LLC  = 3;
    localparam int SLW  = 2;
    localparam int LC   = 8;
    localparam int SW   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_stride_we;
    logic [LLC-1:0]       cfg_depth;
    logic [AB-1:0]        cfg_stride;
    logic                 cfg_base_we;
    logic [AB-1:0]        cfg_base;
    logic                 enable;
    logic                 is_start_loop;
    logic [LLC-1:0]       loop_depth;
    logic [BITS-1:0]      cur_di;
    logic                 loop_done;
    logic [SW*AB-1:0]     lane_addr;
    logic [SW-1:0]        lane_valid;
    logic                 out_valid;
    logic [AB-1:0]        cur_addr;

    loop_apu #(.BITS(BITS), .ADDR_BITS(AB), .LOOP_LOG_CNT(LLC), .SUPERSCALAR_LOG_WIDTH(SLW)) dut (
        .clk(clk), .reset(reset), .cfg_stride_we(cfg_stride_we), .cfg_depth(cfg_depth),
        .cfg_stride(cfg_stride), .cfg_base_we(cfg_base_we), .cfg_base(cfg_base),
        .enable(enable), .is_start_loop(is_start_loop), .loop_depth(loop_depth),
        .cur_di(cur_di), .loop_done(loop_done), .lane_addr(lane_addr),
        .lane_valid(lane_valid), .out_valid(out_valid), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: strides, snapshots, running address and expected outputs.
    logic [AB-1:0] m_stride [LC];
    logic [AB-1:0] m_snap   [LC];
    logic [AB-1:0] m_cur;
    logic [AB-1:0] e_lane   [SW];
    logic [SW-1:0] e_valid;
    logic          e_ov;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; cfg_stride_we = 1'b0; cfg_depth = '0; cfg_stride = '0;
        cfg_base_we = 1'b0; cfg_base = '0; enable = 1'b0; is_start_loop = 1'b0;
        loop_depth = '0; cur_di = '0; loop_done = 1'b0;
    endtask

    // Advance the model by one cycle using the driven inputs, clock the DUT, compare.
    task automatic tick(input string tag);
        int eff;
        logic [AB-1:0] ncur;
        logic step;
        ncur = m_cur;
        if (reset) begin
            for (int i = 0; i < LC; i++) begin m_stride[i] = '0; m_snap[i] = '0; end
            for (int k = 0; k < SW; k++) e_lane[k] = '0;
            e_valid = '0; e_ov = 1'b0; ncur = '0;
        end else begin
            step = enable && !is_start_loop && (cur_di != 0);
            e_valid = '0; e_ov = 1'b0;
            if (step) begin
                eff = (cur_di > SW) ? SW : int'(cur_di);
                for (int k = 0; k < SW; k++) begin
                    e_lane[k] = m_cur + AB'(k) * m_stride[loop_depth];
                    if (k < eff) e_valid[k] = 1'b1;
                end
                e_ov = 1'b1;
                ncur = loop_done ? m_snap[loop_depth] : m_cur + AB'(eff) * m_stride[loop_depth];
            end
            if (enable && is_start_loop && !cfg_base_we) m_snap[loop_depth] = m_cur;
            if (cfg_base_we) ncur = cfg_base;
            if (cfg_stride_we) m_stride[cfg_depth] = cfg_stride;
        end
        m_cur = ncur;
        @(posedge clk);
        #1;
        check({tag, ".cur_addr"}, 64'(cur_addr), 64'(m_cur));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        check({tag, ".lane_valid"}, 64'(lane_valid), 64'(e_valid));
        if (e_ov || reset) begin
            for (int k = 0; k < SW; k++)
                check($sformatf("%s.lane%0d", tag, k), 64'(lane_addr[k*AB +: AB]), 64'(e_lane[k]));
        end
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs(); reset = 1'b1; tick("reset");
    endtask
    task automatic set_stride(input int d, input logic [AB-1:0] s);
        cfg_stride_we = 1'b1; cfg_depth = LLC'(d); cfg_stride = s; tick("stride");
    endtask
    task automatic set_base(input logic [AB-1:0] b);
        cfg_base_we = 1'b1; cfg_base = b; tick("base");
    endtask
    task automatic do_start(input int d);
        enable = 1'b1; is_start_loop = 1'b1; loop_depth = LLC'(d); tick("start");
    endtask
    task automatic do_step(input string tag, input int d, input int di, input logic done);
        enable = 1'b1; loop_depth = LLC'(d); cur_di = BITS'(di); loop_done = done; tick(tag);
    endtask

    initial begin
        clear_inputs();
        m_cur = '0;
        for (int i = 0; i < LC; i++) begin m_stride[i] = '0; m_snap[i] = '0; end
        @(negedge clk);

        // Strided inner loop.
        do_reset();
        check("rst.lane_addr", 64'(lane_addr), 64'd0);
        set_base(20'h00100); set_stride(0, 20'd4); do_start(0);
        do_step("inner0", 0, 4, 1'b0);
        check("inner0.lane3", 64'(lane_addr[3*AB +: AB]), 64'h10C);
        do_step("inner1", 0, 4, 1'b0);
        check("inner1.lane0", 64'(lane_addr[0 +: AB]), 64'h110);
        do_step("inner2", 0, 2, 1'b1);
        check("inner2.mask", 64'(lane_valid), 64'h3);
        check("inner.end", 64'(cur_addr), 64'h100);

        // Nested rewind.
        do_reset();
        set_stride(0, 20'h00040); set_stride(1, 20'd1);
        do_start(0); do_start(1);
        do_step("nest_a", 1, 1, 1'b0);
        check("nest_a.addr", 64'(lane_addr[0 +: AB]), 64'h000);
        do_step("nest_b", 1, 1, 1'b1);
        check("nest_b.addr", 64'(lane_addr[0 +: AB]), 64'h001);
        do_step("nest_c", 0, 1, 1'b0);
        check("nest_c.addr", 64'(lane_addr[0 +: AB]), 64'h000);
        check("nest.end", 64'(cur_addr), 64'h040);

        // Negative stride and wrap.
        do_reset();
        set_base(20'h00002); set_stride(0, 20'hFFFFF);
        do_step("neg", 0, 4, 1'b0);
        check("neg.lane3", 64'(lane_addr[3*AB +: AB]), 64'hFFFFF);
        check("neg.end", 64'(cur_addr), 64'hFFFFE);

        // Gating and clamping.
        cur_di = BITS'(4); enable = 1'b0; tick("gate_en");
        enable = 1'b1; cur_di = '0; tick("gate_di");
        check("gate.cur", 64'(cur_addr), 64'hFFFFE);
        do_step("clamp", 0, 9, 1'b0);
        check("clamp.mask", 64'(lane_valid), 64'hF);

        // Collisions: base and stride writes alongside a step.
        do_reset();
        set_base(20'h00010); set_stride(0, 20'd2);
        enable = 1'b1; cur_di = BITS'(1); cfg_base_we = 1'b1; cfg_base = 20'h00300;
        cfg_stride_we = 1'b1; cfg_depth = '0; cfg_stride = 20'd8; tick("coll");
        check("coll.lane0", 64'(lane_addr[0 +: AB]), 64'h010);
        check("coll.cur", 64'(cur_addr), 64'h300);
        do_step("coll_next", 0, 2, 1'b0);
        check("coll_next.lane1", 64'(lane_addr[AB +: AB]), 64'h308);

        // Reset mid-run.
        do_step("mid0", 0, 3, 1'b0);
        enable = 1'b1; cur_di = BITS'(4); reset = 1'b1; tick("mid_rst");
        check("mid_rst.valid", 64'(out_valid), 64'd0);
        do_step("mid_after", 0, 4, 1'b0);
        check("mid_after.lane3", 64'(lane_addr[3*AB +: AB]), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 63) == 0);
            cfg_stride_we = ($urandom_range(0, 5) == 0);
            cfg_depth     = LLC'($urandom_range(0, LC - 1));
            cfg_stride    = AB'($urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 32) - 16);
            cfg_base_we   = ($urandom_range(0, 11) == 0);
            cfg_base      = AB'($urandom);
            enable        = ($urandom_range(0, 4) != 0);
            is_start_loop = ($urandom_range(0, 5) == 0);
            loop_depth    = LLC'($urandom_range(0, LC - 1));
            cur_di        = BITS'($urandom_range(0, 7) == 0 ? $urandom_range(5, 1000) : $urandom_range(0, 4));
            loop_done     = ($urandom_range(0, 4) == 0);
            tick($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
